// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings used by the control unit, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_SLL = 3'b011,
    ALU_XOR = 3'b101,
    ALU_SLR = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  function automatic logic [3:0] mkFlags(input logic n, input logic z,
                                         input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_execute_unit_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module iterative_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, accStep;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  // The final step's sum is exposed combinationally so the top can register it on the last edge.
  assign accStep   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = accStep;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (abort_i) begin
        busy_q <= 1'b0;
      end else begin
        acc_q    <= accStep;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == LAST) busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU: single-cycle add/sub/shift/xor with registered result and flags,
// plus a stalling iterative multiply.
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             Stall
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             outValid_q, outValid_d;

  logic [WIDTH-1:0] aluRes;
  logic [3:0]       aluFlags;
  logic [WIDTH:0]   sumExt;
  logic             mulStart, mulAbort, mulDone;
  logic [WIDTH-1:0] mulProduct;

  iterative_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mulStart),
    .abort_i   (mulAbort),
    .mcand_i   (SrcA),
    .mplier_i  (SrcB),
    .done_o    (mulDone),
    .product_o (mulProduct)
  );

  // Undefined encodings fall through to the zero result with only Z set.
  always_comb begin
    sumExt   = '0;
    aluRes   = '0;
    aluFlags = mkFlags(1'b0, 1'b1, 1'b0, 1'b0);
    case (ALUControl)
      ALU_ADD: begin
        sumExt   = {1'b0, SrcA} + {1'b0, SrcB};
        aluRes   = sumExt[WIDTH-1:0];
        aluFlags = mkFlags(aluRes[WIDTH-1], aluRes == '0, sumExt[WIDTH],
                           (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (aluRes[WIDTH-1] != SrcA[WIDTH-1]));
      end
      ALU_SUB: begin
        sumExt   = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
        aluRes   = sumExt[WIDTH-1:0];
        aluFlags = mkFlags(aluRes[WIDTH-1], aluRes == '0, sumExt[WIDTH],
                           (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (aluRes[WIDTH-1] != SrcA[WIDTH-1]));
      end
      ALU_SLL: begin
        aluRes   = SrcA << SrcB[SHW-1:0];
        aluFlags = mkFlags(aluRes[WIDTH-1], aluRes == '0, 1'b0, 1'b0);
      end
      ALU_SLR: begin
        aluRes   = SrcA >> SrcB[SHW-1:0];
        aluFlags = mkFlags(aluRes[WIDTH-1], aluRes == '0, 1'b0, 1'b0);
      end
      ALU_XOR: begin
        aluRes   = SrcA ^ SrcB;
        aluFlags = mkFlags(aluRes[WIDTH-1], aluRes == '0, 1'b0, 1'b0);
      end
      default: ;
    endcase
  end

  // flush outranks in_valid: a flushed accept neither starts a multiply nor loads the outputs.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flags_d    = flags_q;
    outValid_d = 1'b0;
    mulStart   = 1'b0;
    mulAbort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (ALUControl == ALU_MUL) begin
            mulStart = 1'b1;
            state_d  = MUL;
          end else begin
            result_d   = aluRes;
            flags_d    = aluFlags;
            outValid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (flush) begin
          mulAbort = 1'b1;
          state_d  = IDLE;
        end else if (mulDone) begin
          result_d   = mulProduct;
          flags_d    = mkFlags(mulProduct[WIDTH-1], mulProduct == '0, 1'b0, 1'b0);
          outValid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      result_q   <= '0;
      flags_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      outValid_q <= outValid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign Stall     = (state_q == MUL);
  assign out_valid = outValid_q;
  assign ALUResult = result_q;
  assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Bench for alu_execute_unit: vector table plus multiply/flush/reset sequences, checked through a scoreboard.
module tb_alu_execute_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   ALUControl = 3'b000;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         in_ready, out_valid, Stall;
  logic [W-1:0] ALUResult;
  logic [3:0]   ALUFlags;

  alu_execute_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .flush      (flush),
    .out_valid  (out_valid),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags),
    .Stall      (Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           due;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  exp_t sb[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   cycleCnt = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  // Inputs change on the falling edge; due cycle is counted in falling edges from the drive.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit expectOut, input int lat,
                               input logic [W-1:0] res, input logic [3:0] fl);
    @(negedge clk);
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    if (expectOut) sb.push_back('{res, fl, cycleCnt + lat});
  endtask

  task automatic idleCycle();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_result"}, ALUResult, 32'd0);
    checkOutput({tag, "_flags"}, {28'b0, ALUFlags}, 32'd0);
    checkOutput({tag, "_stall"}, {31'b0, Stall}, 32'd0);
  endtask

  // Multiply with cycle-by-cycle stall/ready checks; operands wiggle during MUL and must be ignored.
  task automatic runMul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fl);
    logic [W-1:0] prod;
    prod = a * b;
    applyStimulus(ALU_MUL, a, b, 1'b1, W + 1, prod, fl);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      checkOutput("mul_stall", {31'b0, Stall}, 32'd1);
      checkOutput("mul_in_ready", {31'b0, in_ready}, 32'd0);
      in_valid   = (k <= W - 2);
      ALUControl = ALU_ADD;
      SrcA       = $urandom;
      SrcB       = $urandom;
    end
    @(negedge clk);
    checkOutput("mul_done_stall", {31'b0, Stall}, 32'd0);
    checkOutput("mul_done_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", cycleCnt, e.due);
          checkOutput("result", ALUResult, e.res);
          checkOutput("flags", {28'b0, ALUFlags}, {28'b0, e.flags});
        end
      end else if (sb.size() != 0 && sb[0].due <= cycleCnt) begin
        checkOutput("missing_out_valid", {31'b0, out_valid}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
    vecs[1]  = '{ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
    vecs[2]  = '{ALU_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
    vecs[3]  = '{ALU_SLL, 32'h00000001, 32'd31,       32'h80000000, 4'b1000};
    vecs[4]  = '{ALU_SLR, 32'h80000000, 32'h00000021, 32'h40000000, 4'b0000};
    vecs[5]  = '{ALU_XOR, 32'hFFFF0000, 32'hFFFF0000, 32'h00000000, 4'b0100};
    vecs[6]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
    vecs[7]  = '{ALU_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111};
    vecs[8]  = '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    vecs[9]  = '{3'b100,  32'h00000123, 32'h00000456, 32'h00000000, 4'b0100};
    vecs[10] = '{ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000};
    vecs[11] = '{3'b110,  32'hDEADBEEF, 32'h00000001, 32'h00000000, 4'b0100};
    vecs[12] = '{ALU_SLR, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 4'b1000};

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1, vecs[i].res, vecs[i].flags);
    idleCycle();
    repeat (2) @(negedge clk);

    runMul(32'h00010000, 32'h00010000, 4'b0100);
    runMul(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000);
    runMul(32'h80000001, 32'h00000003, 4'b1000);
    runMul(32'h00001234, 32'h00000010, 4'b0000);
    idleCycle();

    // Flush part-way through a multiply: abort with outputs held.
    applyStimulus(ALU_MUL, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 0, '0, '0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_stall", {31'b0, Stall}, 32'd0);
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_result_held", ALUResult, 32'h00012340);
    checkOutput("flush_flags_held", {28'b0, ALUFlags}, 32'd0);
    applyStimulus(ALU_ADD, 32'd2, 32'd3, 1'b1, 1, 32'd5, 4'b0000);
    idleCycle();
    repeat (2) @(negedge clk);

    // Flush in IDLE cancels an accept on the same cycle, including a multiply start.
    applyStimulus(ALU_ADD, 32'd7, 32'd7, 1'b0, 0, '0, '0);
    flush = 1'b1;
    idleCycle();
    checkOutput("idle_flush_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("idle_flush_result", ALUResult, 32'd5);
    applyStimulus(ALU_MUL, 32'd7, 32'd7, 1'b0, 0, '0, '0);
    flush = 1'b1;
    idleCycle();
    checkOutput("idle_flush_mul_stall", {31'b0, Stall}, 32'd0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a multiply.
    applyStimulus(ALU_MUL, 32'h00000ABC, 32'h00000123, 1'b0, 0, '0, '0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    checkResetValues("mid_mul_reset");
    rst = 1'b0;
    applyStimulus(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1, 32'd0, 4'b0100);
    idleCycle();
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_execute_unit.md
Name: alu_execute_unit

Overview:
Execute-stage ALU; consumes the 3-bit ALUControl produced by the control unit's ALU decoder, plus operands SrcA/SrcB from the ID/EX register.
Single-cycle ops (add, sub, sll, slr, xor) return registered results one cycle after acceptance. mul runs on an iterative shift-add engine and stalls the pipeline until done.
Output feeds the EX/MEM register and the branch/flag logic; branches issue ALUControl=sub for flag generation.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >=8)
SHW, $clog2(WIDTH), shift-amount bits taken from SrcB

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands and ALUControl valid this cycle
in_ready  out  1  unit can accept; transfer occurs when in_valid && in_ready
ALUControl  in  3  op select: 000 add, 001 sub, 010 mul, 011 sll, 101 xor, 111 slr
SrcA  in  WIDTH  operand A
SrcB  in  WIDTH  operand B / shift amount
flush  in  1  abort in-flight op (branch taken / pipeline flush)
out_valid  out  1  ALUResult/ALUFlags valid, single-cycle pulse
ALUResult  out  WIDTH  registered result
ALUFlags  out  4  registered {N,Z,C,V}
Stall  out  1  high while a mul is in progress; to hazard unit

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, ALUResult=0, ALUFlags=0, Stall=0, mul counter/accumulator=0.
- States:
  - IDLE: in_ready=1, Stall=0.
  - MUL: in_ready=0, Stall=1.
- IDLE with accept and non-mul op: next cycle out_valid=1, ALUResult/ALUFlags loaded; stay IDLE. Back-to-back accepts give one result per cycle (latency 1).
- IDLE with accept and op=010: load mcand=SrcA, mplier=SrcB, acc=0, cnt=0; go to MUL. out_valid=0 next cycle.
- MUL, each cycle:
  - if mplier[0], acc += mcand (mod 2^WIDTH); then mcand<<=1, mplier>>=1, cnt++.
  - When cnt==WIDTH-1 the final step's result is written to ALUResult, out_valid=1 next edge, return to IDLE.
  - Fixed latency: out_valid exactly WIDTH+1 cycles after acceptance. Stall is high for WIDTH cycles.
- Arithmetic, all results mod 2^WIDTH:
  - add: A+B.
  - sub: A-B (computed as A+~B+1).
  - sll: A << SrcB[SHW-1:0].
  - slr: logical A >> SrcB[SHW-1:0]; upper SrcB bits are ignored.
  - xor: A^B.
- Flags:
  - N=result[WIDTH-1]; Z=(result==0).
  - add: C=carry-out; V=signed overflow.
  - sub: C=no-borrow (A>=B unsigned); V=signed overflow.
  - mul/sll/slr/xor: C=0, V=0.
- Undefined ALUControl (100, 110, or X): result=0, flags={0,1,0,0}, out_valid still pulses (latency 1); never X on outputs.
- ALUResult/ALUFlags hold their values between out_valid pulses.
- flush:
  - In MUL: abort; next cycle state=IDLE, Stall=0, in_ready=1, no out_valid; ALUResult/ALUFlags unchanged.
  - In IDLE: suppresses out_valid for any op accepted the same cycle. flush has priority over in_valid.
- rst mid-MUL: same as reset values. rst has priority over flush and in_valid.
- in_valid while in_ready=0: ignored. The upstream stage holds its operands under Stall.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] alu_op_t with ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLL, ALU_XOR, ALU_SLR; shared with the control unit.
  - Flag index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef enum for state_t {IDLE, MUL}.
- Sub-module iterative_multiplier (start/done, WIDTH param, holds mcand/mplier/acc/cnt, abort input).
- The top level handles the single-cycle datapath, flags, handshake and output registers.

Test Plan:
- add 0x7FFFFFFF+0x00000001 -> next cycle out_valid=1, ALUResult=0x80000000, ALUFlags=4'b1001.
- sub 5-5, then sub 3-5 back-to-back -> results 0x0 flags 4'b0110, then 0xFFFFFFFE flags 4'b1000; consecutive out_valid pulses.
- mul 0x1234*0x10 -> in_ready=0 and Stall=1 for 32 cycles, out_valid exactly 33 cycles after accept, ALUResult=0x00012340, flags 4'b0000; in_valid during MUL ignored.
- sll 0x1 by 31 -> 0x80000000 flags 4'b1000; slr 0x80000000 with SrcB=0x21 -> 0x40000000; xor 0xFFFF0000^0xFFFF0000 -> 0, Z=1.
- flush asserted on cycle 10 of mul -> no out_valid, Stall=0 and in_ready=1 next cycle, ALUResult unchanged; then add 2+3 -> 5 with latency 1.
- rst on cycle 5 of mul, and ALUControl=3'b100 -> all outputs at reset values after rst; undefined op gives ALUResult=0, flags 4'b0100, no X.
